// File: rtl/coef_fir_sequencer.sv
// coef_fir_sequencer
//   Per accepted sample: shifts a TAPS-deep delay line, streams TAPS signed
//   8-bit coefficients out of an external 64K x 8 RAM (one-cycle read latency)
//   starting at COEF_BASE, multiply-accumulates them against the delay line
//   and emits one arithmetic-shifted, saturated result with a one-cycle pulse.
//   Optional macro COEF_LOAD_EN adds a coefficient write port that performs a
//   single-cycle RAM write (WRITE state). Without it the Data bus is input only
//   and ReadWrite is tied low.
module coef_fir_sequencer #(
   parameter int          TAPS      = 16,
   parameter int          SAMPLE_W  = 16,
   parameter int          ACC_W     = 32,
   parameter logic [15:0] COEF_BASE = 16'h0000,
   parameter int          SHIFT     = 7
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic signed [SAMPLE_W-1:0] SampleIn,
   input  logic                       SampleValid,
   output logic                       SampleReady,
   output logic signed [SAMPLE_W-1:0] OutSample,
   output logic                       OutValid,
   output logic                       Overrun,
   output logic [15:0]                Address,
   inout  wire  [7:0]                 Data,
   output logic                       ReadWrite
`ifdef COEF_LOAD_EN
   ,
   input  logic                       CoefWrEn,
   input  logic [7:0]                 CoefWrIdx,
   input  logic [7:0]                 CoefWrData,
   output logic                       CoefWrReady
`endif
);

   // Counter runs 0..TAPS in FETCH: value c means coefficient c-1 is on Data
   // and address c+1 is the next one to issue.
   localparam int                    CNT_W      = $clog2(TAPS + 1);
   localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(TAPS);
   localparam logic [CNT_W-1:0]      LAST_ISSUE = CNT_W'(TAPS - 1);
   localparam int                    PAD_W      = ACC_W - SAMPLE_W - 8;
   localparam logic signed [ACC_W-1:0] SAT_MAX  =
      {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN  =
      {{(ACC_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

`ifdef COEF_LOAD_EN
   typedef enum logic [1:0] {IDLE, FETCH, DONE, WRITE} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
`endif

   state_t                       state_q;
   logic signed [SAMPLE_W-1:0]   x_q [TAPS];
   logic signed [ACC_W-1:0]      acc_q;
   logic [CNT_W-1:0]             cnt_q;
   logic [15:0]                  addr_q;
   logic signed [SAMPLE_W-1:0]   out_q;
   logic                         out_valid_q;
   logic                         overrun_q;
   logic                         rw_q;
   logic [7:0]                   wr_data_q;

   logic signed [7:0]            coef;
   logic signed [SAMPLE_W-1:0]   x_sel;
   logic signed [SAMPLE_W+7:0]   prod;
   logic signed [ACC_W-1:0]      acc_d;
   logic signed [ACC_W-1:0]      acc_shift;
   logic signed [SAMPLE_W-1:0]   out_d;
   logic                         accept;
   logic                         wr_accept;

   assign SampleReady = (state_q == IDLE);
   assign accept      = SampleValid & SampleReady;

`ifdef COEF_LOAD_EN
   // A pending sample takes priority over a coefficient write.
   assign CoefWrReady = (state_q == IDLE) & ~SampleValid;
   assign wr_accept   = CoefWrEn & CoefWrReady;
   assign Data        = rw_q ? wr_data_q : 8'hzz;
`else
   assign wr_accept   = 1'b0;
`endif

   assign coef = Data;

   // Select the delay-line tap that matches the coefficient currently on Data.
   always_comb begin
      // NOTE: default first so no path through the loop leaves x_sel unassigned (no latch).
      x_sel = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (cnt_q == CNT_W'(k + 1)) x_sel = x_q[k];
      end
   end

   // Full-precision signed product, sign-extended into the accumulator.
   assign prod  = coef * x_sel;
   assign acc_d = acc_q + {{PAD_W{prod[SAMPLE_W+7]}}, prod};

   // Scale the finished sum and clamp it to the output range.
   assign acc_shift = acc_q >>> SHIFT;
   always_comb begin
      if (acc_shift > SAT_MAX)      out_d = SAT_MAX[SAMPLE_W-1:0];
      else if (acc_shift < SAT_MIN) out_d = SAT_MIN[SAMPLE_W-1:0];
      else                          out_d = acc_shift[SAMPLE_W-1:0];
   end

   // Sequencer: sample accept, coefficient fetch/accumulate, result, RAM write.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         // NOTE: the delay line is a small register array, not a RAM; it must
         // start at zero so the first outputs after reset are defined.
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         rw_q        <= 1'b0;
         wr_data_q   <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register samples pre-edge values.
         out_valid_q <= 1'b0;
         if (SampleValid && !SampleReady) overrun_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (accept) begin
                  for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
                  x_q[0]  <= SampleIn;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  addr_q  <= COEF_BASE;
                  state_q <= FETCH;
               end else if (wr_accept) begin
`ifdef COEF_LOAD_EN
                  addr_q    <= COEF_BASE + {8'h00, CoefWrIdx};
                  wr_data_q <= CoefWrData;
                  rw_q      <= 1'b1;
                  state_q   <= WRITE;
`endif
               end
            end

            FETCH: begin
               if (cnt_q < LAST_ISSUE) addr_q <= COEF_BASE + 16'(cnt_q) + 16'd1;
               if (cnt_q != '0)        acc_q  <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT)  state_q <= DONE;
            end

            DONE: begin
               out_q       <= out_d;
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end

`ifdef COEF_LOAD_EN
            WRITE: begin
               rw_q    <= 1'b0;
               state_q <= IDLE;
            end
`endif

            default: state_q <= IDLE;
         endcase
      end
   end

   assign OutSample = out_q;
   assign OutValid  = out_valid_q;
   assign Overrun   = overrun_q;
   assign Address   = addr_q;
`ifdef COEF_LOAD_EN
   assign ReadWrite = rw_q;
`else
   assign ReadWrite = 1'b0;
`endif

endmodule

// File: tb/tb_coef_fir_sequencer.sv
// Self-checking bench for coef_fir_sequencer: two instances (A: TAPS=4,
// SHIFT=0, base FFFE; B: TAPS=5, SHIFT=3, base 0100), each with its own RAM
// model, reference model and output scoreboard.
`timescale 1ns/1ps
module tb_coef_fir_sequencer;

   localparam int          TA    = 4;
   localparam int          SA    = 0;
   localparam logic [15:0] BA    = 16'hFFFE;
   localparam int          TB    = 5;
   localparam int          SB    = 3;
   localparam logic [15:0] BB    = 16'h0100;
   localparam int          NEVER = 32'h7fff_ffff;

   typedef struct {
      int value;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A signals / RAM ----------------
   logic signed [15:0] a_in;
   logic               a_valid, a_ready, a_ovalid, a_ovr, a_rw;
   logic signed [15:0] a_out;
   logic [15:0]        a_addr;
   wire  [7:0]         a_data;
   logic [7:0]         ram_a [0:65535];
   logic [7:0]         ram_a_q;
   logic               a_wen, a_wready;
   logic [7:0]         a_widx, a_wdata;

   always @(posedge clk) begin
      if (a_rw) ram_a[a_addr] <= a_data;
      ram_a_q <= ram_a[a_addr];
   end
   assign a_data = a_rw ? 8'hzz : ram_a_q;

   // ---------------- instance B signals / RAM ----------------
   logic signed [15:0] b_in;
   logic               b_valid, b_ready, b_ovalid, b_ovr, b_rw;
   logic signed [15:0] b_out;
   logic [15:0]        b_addr;
   wire  [7:0]         b_data;
   logic [7:0]         ram_b [0:65535];
   logic [7:0]         ram_b_q;
   logic               b_wen, b_wready;
   logic [7:0]         b_widx, b_wdata;

   always @(posedge clk) begin
      if (b_rw) ram_b[b_addr] <= b_data;
      ram_b_q <= ram_b[b_addr];
   end
   assign b_data = b_rw ? 8'hzz : ram_b_q;

   coef_fir_sequencer #(.TAPS(TA), .SAMPLE_W(16), .ACC_W(32), .COEF_BASE(BA), .SHIFT(SA)) dut_a (
      .Clock(clk), .Reset(rst_n), .SampleIn(a_in), .SampleValid(a_valid),
      .SampleReady(a_ready), .OutSample(a_out), .OutValid(a_ovalid), .Overrun(a_ovr),
      .Address(a_addr), .Data(a_data), .ReadWrite(a_rw)
`ifdef COEF_LOAD_EN
      , .CoefWrEn(a_wen), .CoefWrIdx(a_widx), .CoefWrData(a_wdata), .CoefWrReady(a_wready)
`endif
   );

   coef_fir_sequencer #(.TAPS(TB), .SAMPLE_W(16), .ACC_W(32), .COEF_BASE(BB), .SHIFT(SB)) dut_b (
      .Clock(clk), .Reset(rst_n), .SampleIn(b_in), .SampleValid(b_valid),
      .SampleReady(b_ready), .OutSample(b_out), .OutValid(b_ovalid), .Overrun(b_ovr),
      .Address(b_addr), .Data(b_data), .ReadWrite(b_rw)
`ifdef COEF_LOAD_EN
      , .CoefWrEn(b_wen), .CoefWrIdx(b_widx), .CoefWrData(b_wdata), .CoefWrReady(b_wready)
`endif
   );

   // ---------------- reference model state ----------------
   int   coef_a[$], coef_b[$];
   int   xa[$], xb[$];
   exp_t qa[$], qb[$];
   int   busy_a = 0, busy_b = 0;
   int   ov_a = NEVER, ov_b = NEVER;
   int   wr_edge = -1;

   task automatic check(input string name, input logic signed [31:0] actual,
                        input logic signed [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Direct-form FIR sum of products, arithmetic scaling, clamp to 16 bits.
   function automatic int fir_ref(input int xs[$], input int cs[$], input int shift);
      longint acc = 0;
      for (int k = 0; k < cs.size(); k++) acc += longint'(cs[k]) * longint'(xs[k]);
      acc = acc >>> shift;
      if (acc > 32767)  return 32767;
      if (acc < -32768) return -32768;
      return int'(acc);
   endfunction

   function automatic int rnd_sample();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   function automatic int rnd_coef();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic set_coef_a(input int k, input int v);
      logic [15:0] ad;
      coef_a[k] = v;
      ad = BA + 16'(k);
      ram_a[ad] = v[7:0];
   endtask

   task automatic set_coef_b(input int k, input int v);
      logic [15:0] ad;
      coef_b[k] = v;
      ad = BB + 16'(k);
      ram_b[ad] = v[7:0];
   endtask

   task automatic model_reset();
      qa.delete(); qb.delete(); xa.delete(); xb.delete();
      for (int k = 0; k < TA; k++) xa.push_back(0);
      for (int k = 0; k < TB; k++) xb.push_back(0);
      busy_a = 0; busy_b = 0; ov_a = NEVER; ov_b = NEVER; wr_edge = -1;
   endtask

   // Called at a negedge: offers a sample for the coming edge and predicts
   // whether it is taken (block idle) or dropped (overrun).
   task automatic offer_a(input int s);
      a_valid = 1'b1;
      a_in    = s[15:0];
      check("a_ready", a_ready, cyc + 1 >= busy_a);
      if (cyc + 1 >= busy_a) begin
         xa.push_front(s);
         void'(xa.pop_back());
         qa.push_back('{fir_ref(xa, coef_a, SA), cyc + 1 + TA + 2});
         busy_a = cyc + 1 + TA + 3;
      end else if (ov_a == NEVER) begin
         ov_a = cyc + 1;
      end
   endtask

   task automatic offer_b(input int s);
      b_valid = 1'b1;
      b_in    = s[15:0];
      check("b_ready", b_ready, cyc + 1 >= busy_b);
      if (cyc + 1 >= busy_b) begin
         xb.push_front(s);
         void'(xb.pop_back());
         qb.push_back('{fir_ref(xb, coef_b, SB), cyc + 1 + TB + 2});
         busy_b = cyc + 1 + TB + 3;
      end else if (ov_b == NEVER) begin
         ov_b = cyc + 1;
      end
   endtask

   task automatic send_a(input int s);
      @(negedge clk);
      a_valid = 1'b0;
      while (cyc + 1 < busy_a) @(negedge clk);
      offer_a(s);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) begin
         @(negedge clk);
         a_valid = 1'b0;
         b_valid = 1'b0;
      end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

`ifdef COEF_LOAD_EN
   task automatic write_a(input int idx, input int val);
      logic signed [7:0] v8;
      logic [15:0]       ea;
      @(negedge clk);
      a_valid = 1'b0;
      while (cyc + 1 < busy_a) @(negedge clk);
      a_wen = 1'b1; a_widx = idx[7:0]; a_wdata = val[7:0];
      #1 check("a_wready", a_wready, 1);
      wr_edge = cyc + 1;
      busy_a  = cyc + 3;
      v8 = val[7:0];
      if (idx < TA) coef_a[idx] = v8;
      @(negedge clk);
      a_wen = 1'b0;
      ea = BA + 16'(idx);
      check("a_wr_addr", a_addr, ea);
      check("a_wr_data", a_data, val[7:0]);
   endtask
`endif

   // Scoreboard monitors: sample outputs on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("a_overrun", a_ovr, cyc >= ov_a);
         check("a_rw", a_rw, cyc == wr_edge);
         if (qa.size() != 0 && cyc > qa[0].due) begin
            checks++; errors++;
            $display("FAIL a_missing_out: got none expected %0d due cycle %0d", qa[0].value, qa[0].due);
            void'(qa.pop_front());
         end
         if (a_ovalid) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_out: got %0d expected no pulse (cycle %0d)", a_out, cyc);
            end else begin
               e = qa.pop_front();
               check("a_out", a_out, e.value);
               check("a_out_cycle", cyc, e.due);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("b_overrun", b_ovr, cyc >= ov_b);
         check("b_rw", b_rw, 0);
         if (qb.size() != 0 && cyc > qb[0].due) begin
            checks++; errors++;
            $display("FAIL b_missing_out: got none expected %0d due cycle %0d", qb[0].value, qb[0].due);
            void'(qb.pop_front());
         end
         if (b_ovalid) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected_out: got %0d expected no pulse (cycle %0d)", b_out, cyc);
            end else begin
               e = qb.pop_front();
               check("b_out", b_out, e.value);
               check("b_out_cycle", cyc, e.due);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] ea;
      a_valid = 0; a_in = 0; b_valid = 0; b_in = 0;
      a_wen = 0; a_widx = 0; a_wdata = 0; b_wen = 0; b_widx = 0; b_wdata = 0;
      for (int i = 0; i < 65536; i++) begin
         ram_a[i] = 8'($urandom);
         ram_b[i] = 8'($urandom);
      end
      for (int k = 0; k < TA; k++) coef_a.push_back(0);
      for (int k = 0; k < TB; k++) coef_b.push_back(0);
      model_reset();
      set_coef_a(0, 2); set_coef_a(1, -1); set_coef_a(2, 3); set_coef_a(3, -128);
      for (int k = 0; k < TB; k++) set_coef_b(k, rnd_coef());

      // Reset state.
      #1;
      check("rst_a_out", a_out, 0);       check("rst_a_valid", a_ovalid, 0);
      check("rst_a_ovr", a_ovr, 0);       check("rst_a_ready", a_ready, 1);
      check("rst_a_addr", a_addr, 0);     check("rst_a_rw", a_rw, 0);
      check("rst_b_addr", b_addr, 0);     check("rst_b_ready", b_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Impulse, with the wrapping address trace of the first fetch.
      send_a(100);
      for (int n = 0; n < TA; n++) begin
         @(negedge clk);
         a_valid = 1'b0;
         ea = BA + 16'(n);
         check("a_fetch_addr", a_addr, ea);
      end
      send_a(0); send_a(0); send_a(0);
      drain();

      // Saturation at both rails.
      for (int k = 0; k < TA; k++) set_coef_a(k, 127);
      repeat (4) send_a(32767);
      repeat (4) send_a(-32768);
      drain();

      // SampleValid held high: one accept per TAPS+3 clocks, rest dropped.
      repeat (30) begin
         @(negedge clk);
         offer_a(rnd_sample());
      end
      drain();

      // Random coefficients and sporadic offers on both instances.
      for (int k = 0; k < TA; k++) set_coef_a(k, rnd_coef());
      for (int k = 0; k < TB; k++) set_coef_b(k, rnd_coef());
      fork
         for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) offer_a(rnd_sample()); else a_valid = 1'b0;
         end
         for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) offer_b(rnd_sample()); else b_valid = 1'b0;
         end
      join
      drain();

      // Reset in the middle of a fetch: aborts, clears, no output pulse.
      set_coef_a(0, 2); set_coef_a(1, -1); set_coef_a(2, 3); set_coef_a(3, -128);
      send_a(100);
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_a_addr", a_addr, 0);
      check("midrst_a_valid", a_ovalid, 0);
      check("midrst_a_ready", a_ready, 1);
      check("midrst_a_ovr", a_ovr, 0);
      check("midrst_b_ovr", b_ovr, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      send_a(100);
      drain();

`ifdef COEF_LOAD_EN
      // Coefficient write, then an impulse that reads it back.
      repeat (TA) send_a(0);
      drain();
      write_a(1, 8'h05);
      send_a(10); send_a(0);
      drain();
      // Sample and write offered together: the sample wins, no write happens.
      @(negedge clk);
      while (cyc + 1 < busy_a) @(negedge clk);
      offer_a(7);
      a_wen = 1'b1; a_widx = 8'd2; a_wdata = 8'h11;
      #1 check("a_wready_tie", a_wready, 0);
      @(negedge clk);
      a_valid = 1'b0; a_wen = 1'b0;
      drain();
      ea = BA + 16'd2;
      check("a_tie_no_write", ram_a[ea], coef_a[2] & 8'hFF);
`endif

      check("a_queue_empty", qa.size(), 0);
      check("b_queue_empty", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coef_fir_sequencer.md
Name: coef_fir_sequencer

Overview:
- Direct upstream client of the synth's 64K x 8 coefficient RAM (shared tristate Data bus, ReadWrite: 1=write, 0=read).
- For each accepted audio sample it shifts a TAPS-deep delay line and reads TAPS signed 8-bit coefficients from RAM starting at COEF_BASE.
- It multiply-accumulates them against the delay line and emits one scaled, saturated filtered sample.

Parameters:
TAPS, 16, number of filter taps (2..256)
SAMPLE_W, 16, signed sample width in and out
ACC_W, 32, signed accumulator width (must be >= SAMPLE_W+8+clog2(TAPS))
COEF_BASE, 16'h0000, RAM address of coefficient 0; coefficient k at COEF_BASE+k, mod 2^16
SHIFT, 7, arithmetic right shift applied to accumulator before saturation

Ports:
Clock  in  1  system clock, all state on posedge
Reset  in  1  asynchronous, active-low reset
SampleIn  in  SAMPLE_W  signed input sample
SampleValid  in  1  input sample offered
SampleReady  out  1  block can accept a sample this cycle
OutSample  out  SAMPLE_W  signed filtered result
OutValid  out  1  one-cycle pulse, OutSample valid
Overrun  out  1  sticky: a sample was offered while not ready
Address  out  16  RAM address, registered
Data  inout  8  RAM data bus; read-only unless COEF_LOAD_EN
ReadWrite  out  1  RAM direction, registered

Behaviour:
- Reset (Reset=0, async):
  - State IDLE, delay line all 0, accumulator 0.
  - OutSample=0, OutValid=0, Overrun=0, SampleReady=1.
  - Address=0, ReadWrite=0, Data released (Z).
  - Reset mid-operation aborts the computation with no output pulse.
- RAM timing contract:
  - RAM samples Address/ReadWrite at posedge; read data appears on Data after that edge.
  - The block captures read data at the following edge, giving one-cycle read latency.
- States: IDLE, FETCH, DONE (+WRITE with macro).
- SampleReady=1 only in IDLE. Accept = SampleValid & SampleReady.
- On accept, edge E0:
  - x[k]<=x[k-1] for k=TAPS-1..1; x[0]<=SampleIn.
  - acc<=0, issue index i<=1, Address<=COEF_BASE, state->FETCH.
- FETCH:
  - Each edge, Address<=COEF_BASE+i and i increments while i<TAPS.
  - At edge E(k+2), acc<=acc+sext(Data)*x[k] for k=0..TAPS-1; products are full signed, sign-extended to ACC_W.
  - After the k=TAPS-1 accumulate at E(TAPS+1), state->DONE.
- DONE (edge E(TAPS+2)):
  - OutSample<=sat(acc>>>SHIFT), where sat clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - OutValid<=1 for exactly one cycle; state->IDLE.
  - OutSample holds between pulses.
- Latency: accept edge to OutValid high = TAPS+2 clocks. Max throughput: one sample per TAPS+3 clocks.
- Overrun: SampleValid=1 while SampleReady=0 sets Overrun=1 until reset; the offered sample is dropped and the delay line is unchanged.
- Address wrap: COEF_BASE+k is computed mod 2^16 (e.g. base 16'hFFFE, TAPS=4 reads FFFE, FFFF, 0000, 0001).
- ReadWrite=0 and Data=Z in all states except WRITE.

Optional Feature:
- Macro: COEF_LOAD_EN.
- Defined:
  - Adds ports CoefWrEn in 1, CoefWrIdx in 8, CoefWrData in 8, CoefWrReady out 1.
  - CoefWrReady = IDLE & ~SampleValid, so a sample wins a tie.
  - On CoefWrEn & CoefWrReady, next state is WRITE for exactly one cycle: Address=COEF_BASE+CoefWrIdx, ReadWrite=1, Data driven with CoefWrData. Then back to IDLE with ReadWrite=0 and Data=Z.
  - SampleReady=0 during WRITE.
  - CoefWrIdx >= TAPS is still written (no check).
- Undefined: these ports do not exist, ReadWrite is constant 0, Data is never driven.

Test Plan:
- Impulse (TAPS=4, SHIFT=0, RAM[0..3]=02,FF,03,80): sample 100 then three 0s -> OutSample 200, -100, 300, -12800; each OutValid exactly 6 clocks after its accept.
- Saturation (TAPS=4, SHIFT=0, all coefs 7F): four samples 32767 -> last output 32767; four samples -32768 -> last output -32768.
- Overrun: SampleValid held high continuously -> accepts exactly every 7 clocks (TAPS=4), Overrun=1 after first rejected cycle, outputs still correct.
- Wrap (COEF_BASE=16'hFFFE, TAPS=4) -> Address sequence FFFE, FFFF, 0000, 0001; ReadWrite stays 0, Data never driven.
- Reset asserted during FETCH -> immediate IDLE, Address=0, no OutValid; next impulse sees zeroed delay line (output matches first impulse case).
- COEF_LOAD_EN: write idx 1 = 05, then impulse 10 -> second output 50; one WRITE cycle with ReadWrite=1 and Data=05 observed; simultaneous SampleValid blocks CoefWrReady.
